// File: rtl/fcpu_io_axi_bridge_if.sv
// AXI4 subset carried between the fcpu io master port and the serial bridge.
// Only the fields the bridge consumes are present; address and attributes are dropped upstream.
interface fcpu_io_axi_bridge_if #(
   parameter int unsigned ID_W = 4
);
   logic [ID_W-1:0] awid;
   logic [7:0]      awlen;
   logic            awvalid;
   logic            awready;

   logic [7:0]      wdata;
   logic            wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;

   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   logic [ID_W-1:0] arid;
   logic [7:0]      arlen;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [7:0]      rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   modport master (
      output awid, awlen, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, arlen, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awlen, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, arlen, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/fcpu_io_axi_bridge.sv
// Terminates the fcpu AXI4 io port onto the serial byte stream: writes become tx bytes,
// reads drain a small RX FIFO that collects bytes even while no read is outstanding.
module fcpu_io_axi_bridge #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ID_W       = 4
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   fcpu_io_axi_bridge_if.slave   io,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic       {RIdle, RData}        r_state_e;

   // Held low through reset so the address readies only rise once reset is released.
   logic            live_q;

   w_state_e        w_state_q, w_state_d;
   logic [7:0]      wcnt_q, wcnt_d;
   logic [ID_W-1:0] wid_q, wid_d;
   logic            werr_q, werr_d;
   logic            beat_ready;

   r_state_e        r_state_q, r_state_d;
   logic [7:0]      rcnt_q, rcnt_d;
   logic [ID_W-1:0] rid_q, rid_d;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            fifo_empty, fifo_full;
   logic            push, pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
   assign rx_ready   = live_q & ~fifo_full;
   assign push       = rx_valid & rx_ready;
   assign io.rresp   = 2'b00;

   // Write channel: strobe-0 beats are swallowed without waiting on the transmitter.
   always_comb begin
      w_state_d  = w_state_q;
      wcnt_d     = wcnt_q;
      wid_d      = wid_q;
      werr_d     = werr_q;
      beat_ready = io.wstrb ? tx_ready : 1'b1;
      io.awready = 1'b0;
      io.wready  = 1'b0;
      io.bvalid  = 1'b0;
      io.bid     = '0;
      io.bresp   = 2'b00;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      unique case (w_state_q)
         WIdle: begin
            io.awready = live_q;
            if (io.awvalid && live_q) begin
               wid_d     = io.awid;
               wcnt_d    = io.awlen;
               werr_d    = 1'b0;
               w_state_d = WData;
            end
         end
         WData: begin
            tx_data   = io.wdata;
            tx_valid  = io.wvalid & io.wstrb;
            io.wready = beat_ready;
            if (io.wvalid && beat_ready) begin
               if (io.wlast != (wcnt_q == 8'd0)) begin
                  werr_d = 1'b1;
               end
               // The beat counter, not wlast, ends the burst.
               if (wcnt_q == 8'd0) begin
                  w_state_d = WResp;
               end else begin
                  wcnt_d = wcnt_q - 8'd1;
               end
            end
         end
         WResp: begin
            io.bvalid = 1'b1;
            io.bid    = wid_q;
            io.bresp  = werr_q ? 2'b10 : 2'b00;
            if (io.bready) begin
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   // Read channel: beats stall with rvalid low until the FIFO has data.
   always_comb begin
      r_state_d  = r_state_q;
      rcnt_d     = rcnt_q;
      rid_d      = rid_q;
      pop        = 1'b0;
      io.arready = 1'b0;
      io.rvalid  = 1'b0;
      io.rdata   = 8'h00;
      io.rlast   = 1'b0;
      io.rid     = '0;
      unique case (r_state_q)
         RIdle: begin
            io.arready = live_q;
            if (io.arvalid && live_q) begin
               rid_d     = io.arid;
               rcnt_d    = io.arlen;
               r_state_d = RData;
            end
         end
         RData: begin
            io.rvalid = ~fifo_empty;
            io.rdata  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
            io.rlast  = (rcnt_q == 8'd0);
            io.rid    = rid_q;
            if (!fifo_empty && io.rready) begin
               pop = 1'b1;
               if (rcnt_q == 8'd0) begin
                  r_state_d = RIdle;
               end else begin
                  rcnt_d = rcnt_q - 8'd1;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         live_q    <= 1'b0;
         w_state_q <= WIdle;
         wcnt_q    <= 8'd0;
         wid_q     <= '0;
         werr_q    <= 1'b0;
         r_state_q <= RIdle;
         rcnt_q    <= 8'd0;
         rid_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         live_q    <= 1'b1;
         w_state_q <= w_state_d;
         wcnt_q    <= wcnt_d;
         wid_q     <= wid_d;
         werr_q    <= werr_d;
         r_state_q <= r_state_d;
         rcnt_q    <= rcnt_d;
         rid_q     <= rid_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Storage needs no reset: count_q gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

endmodule

// File: tb/tb_fcpu_io_axi_bridge.sv
// Bench for fcpu_io_axi_bridge: a transaction-level model with a byte queue predicts every
// output each cycle, and directed scenarios pin byte order, responses and reset behaviour.
module tb_fcpu_io_axi_bridge;
   localparam int unsigned Depth = 16;
   localparam int unsigned IdW   = 4;

   logic       clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   fcpu_io_axi_bridge_if #(.ID_W(IdW)) io ();

   fcpu_io_axi_bridge #(
      .FIFO_DEPTH (Depth),
      .ID_W       (IdW)
   ) dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .io        (io),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s: got no handshake, want one at %0t", nm, $time);
   endtask

   // ---------------- transaction-level model ----------------
   bit         m_alive = 1'b0;
   bit         m_wbusy = 1'b0, m_resp = 1'b0, m_err = 1'b0;
   int         m_wleft = 0;
   logic [3:0] m_wid = '0;
   bit         m_rbusy = 1'b0;
   int         m_rleft = 0;
   logic [3:0] m_rid = '0;
   logic [7:0] m_fifo[$];
   logic [7:0] m_txlog[$];
   logic [7:0] dut_tx[$];

   function automatic logic e_awready(); return m_alive && !m_wbusy && !m_resp; endfunction
   function automatic logic e_wready();
      return m_wbusy && (io.wstrb ? tx_ready : 1'b1);
   endfunction
   function automatic logic e_txvalid(); return m_wbusy && io.wvalid && io.wstrb; endfunction
   function automatic logic [7:0] e_txdata(); return m_wbusy ? io.wdata : 8'h00; endfunction
   function automatic logic [3:0] e_bid(); return m_resp ? m_wid : 4'h0; endfunction
   function automatic logic [1:0] e_bresp();
      return (m_resp && m_err) ? 2'b10 : 2'b00;
   endfunction
   function automatic logic e_arready(); return m_alive && !m_rbusy; endfunction
   function automatic logic e_rvalid(); return m_rbusy && (m_fifo.size() > 0); endfunction
   function automatic logic [7:0] e_rdata();
      if (m_rbusy && m_fifo.size() > 0) return m_fifo[0];
      return 8'h00;
   endfunction
   function automatic logic e_rlast(); return m_rbusy && (m_rleft == 0); endfunction
   function automatic logic [3:0] e_rid(); return m_rbusy ? m_rid : 4'h0; endfunction
   function automatic logic e_rxready(); return m_alive && (m_fifo.size() < Depth); endfunction

   always @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_alive <= 1'b0;
         m_wbusy <= 1'b0;
         m_resp  <= 1'b0;
         m_err   <= 1'b0;
         m_wleft <= 0;
         m_wid   <= '0;
         m_rbusy <= 1'b0;
         m_rleft <= 0;
         m_rid   <= '0;
         m_fifo.delete();
      end else begin
         automatic bit aw_hs = io.awvalid && e_awready();
         automatic bit w_hs  = io.wvalid && e_wready();
         automatic bit b_hs  = m_resp && io.bready;
         automatic bit ar_hs = io.arvalid && e_arready();
         automatic bit r_hs  = io.rready && e_rvalid();
         automatic bit rx_hs = rx_valid && e_rxready();
         automatic bit tx_hs = e_txvalid() && tx_ready;
         m_alive <= 1'b1;
         if (tx_hs) m_txlog.push_back(io.wdata);
         if (aw_hs) begin
            m_wbusy <= 1'b1;
            m_wleft <= int'(io.awlen);
            m_wid   <= io.awid;
            m_err   <= 1'b0;
         end
         if (w_hs) begin
            if (io.wlast != (m_wleft == 0)) m_err <= 1'b1;
            if (m_wleft == 0) begin
               m_wbusy <= 1'b0;
               m_resp  <= 1'b1;
            end else begin
               m_wleft <= m_wleft - 1;
            end
         end
         if (b_hs) m_resp <= 1'b0;
         if (ar_hs) begin
            m_rbusy <= 1'b1;
            m_rleft <= int'(io.arlen);
            m_rid   <= io.arid;
         end
         if (r_hs) begin
            void'(m_fifo.pop_front());
            if (m_rleft == 0) m_rbusy <= 1'b0;
            else m_rleft <= m_rleft - 1;
         end
         if (rx_hs) m_fifo.push_back(rx_data);
      end
   end

   // Every output checked against the model each cycle, mid-cycle.
   always @(negedge clk) begin
      chk("awready", io.awready, e_awready());
      chk("wready",  io.wready,  e_wready());
      chk("tx_valid", tx_valid,  e_txvalid());
      chk("tx_data", tx_data,    e_txdata());
      chk("bvalid",  io.bvalid,  m_resp);
      chk("bid",     io.bid,     e_bid());
      chk("bresp",   io.bresp,   e_bresp());
      chk("arready", io.arready, e_arready());
      chk("rvalid",  io.rvalid,  e_rvalid());
      chk("rdata",   io.rdata,   e_rdata());
      chk("rlast",   io.rlast,   e_rlast());
      chk("rid",     io.rid,     e_rid());
      chk("rresp",   io.rresp,   2'b00);
      chk("rx_ready", rx_ready,  e_rxready());
      if (tx_valid === 1'b1 && tx_ready === 1'b1) dut_tx.push_back(tx_data);
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] got_d[$];
   logic       got_l[$];
   logic [3:0] got_id[$];
   logic [3:0] cap_bid;
   logic [1:0] cap_bresp;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_aw(input logic [3:0] id, input logic [7:0] len);
      bit ok;
      ok = 1'b0;
      io.awid = id; io.awlen = len; io.awvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (io.awready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("aw_hs");
      step();
      io.awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [7:0] d, input logic strb, input logic last);
      bit ok;
      ok = 1'b0;
      io.wdata = d; io.wstrb = strb; io.wlast = last; io.wvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (io.wready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("w_hs");
      step();
      io.wvalid = 1'b0;
   endtask

   task automatic do_b();
      bit ok;
      ok = 1'b0;
      io.bready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (io.bvalid === 1'b1) begin
            ok = 1'b1; cap_bid = io.bid; cap_bresp = io.bresp; break;
         end
      end
      if (!ok) timeout_fail("b_hs");
      step();
      io.bready = 1'b0;
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [7:0] len);
      bit ok;
      ok = 1'b0;
      io.arid = id; io.arlen = len; io.arvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (io.arready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("ar_hs");
      step();
      io.arvalid = 1'b0;
   endtask

   task automatic do_push(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      rx_data = d; rx_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rx_ready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) timeout_fail("rx_hs");
      step();
      rx_valid = 1'b0;
   endtask

   task automatic collect(input int n);
      got_d.delete(); got_l.delete(); got_id.delete();
      io.rready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (io.rvalid === 1'b1) begin
            got_d.push_back(io.rdata); got_l.push_back(io.rlast); got_id.push_back(io.rid);
            if (got_d.size() == n) break;
         end
      end
      if (got_d.size() != n) timeout_fail("r_beats");
      step();
      io.rready = 1'b0;
   endtask

   function automatic logic [25:0] axi_outs();
      return {io.awready, io.wready, io.bvalid, io.bid, io.bresp, io.arready, io.rvalid,
              io.rdata, io.rlast, io.rid, io.rresp};
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      io.awid = '0; io.awlen = '0; io.awvalid = 1'b0;
      io.wdata = '0; io.wstrb = 1'b0; io.wlast = 1'b0; io.wvalid = 1'b0;
      io.bready = 1'b0;
      io.arid = '0; io.arlen = '0; io.arvalid = 1'b0;
      io.rready = 1'b0;

      // Reset state
      step();
      chk("rst_axi_outs", 32'(axi_outs()), 32'h0);
      chk("rst_stream_outs", {tx_valid, tx_data, rx_ready}, 32'h0);
      step();
      sys_rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("post_rst_awready", io.awready, 1'b1);
      chk("post_rst_arready", io.arready, 1'b1);
      chk("post_rst_rx_ready", rx_ready, 1'b1);
      step();

      // 1: single-beat write
      dut_tx.delete(); m_txlog.delete();
      do_aw(4'd3, 8'd0);
      do_w(8'h41, 1'b1, 1'b1);
      do_b();
      chk("t1_bid", cap_bid, 4'd3);
      chk("t1_bresp", cap_bresp, 2'b00);
      chk("t1_tx_count", dut_tx.size(), 1);
      if (dut_tx.size() == 1) chk("t1_tx_byte", dut_tx[0], 8'h41);
      if (m_txlog.size() == 1) chk("t1_model_byte", m_txlog[0], 8'h41);
      else chk("t1_model_count", m_txlog.size(), 1);

      // 2: four-beat write with transmitter stall on beat 2
      dut_tx.delete();
      do_aw(4'd1, 8'd3);
      do_w(8'h10, 1'b1, 1'b0);
      do_w(8'h11, 1'b1, 1'b0);
      tx_ready = 1'b0;
      io.wdata = 8'h12; io.wstrb = 1'b1; io.wlast = 1'b0; io.wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_stall_wready", io.wready, 1'b0);
         step();
      end
      tx_ready = 1'b1;
      do_w(8'h12, 1'b1, 1'b0);
      do_w(8'h13, 1'b1, 1'b1);
      do_b();
      chk("t2_bresp", cap_bresp, 2'b00);
      chk("t2_tx_count", dut_tx.size(), 4);
      for (int i = 0; i < 4 && i < dut_tx.size(); i++) chk("t2_tx_byte", dut_tx[i], 8'h10 + i);

      // 3: early wlast, counter still governs
      dut_tx.delete();
      do_aw(4'd2, 8'd1);
      do_w(8'h20, 1'b1, 1'b1);
      do_w(8'h21, 1'b1, 1'b1);
      do_b();
      chk("t3_bresp", cap_bresp, 2'b10);
      chk("t3_tx_count", dut_tx.size(), 2);

      // 4: read issued before data arrives
      do_ar(4'd5, 8'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t4_rvalid_idle", io.rvalid, 1'b0);
         step();
      end
      fork
         begin do_push(8'hAA); do_push(8'hBB); end
         collect(2);
      join
      if (got_d.size() == 2) begin
         chk("t4_rdata0", got_d[0], 8'hAA);
         chk("t4_rlast0", got_l[0], 1'b0);
         chk("t4_rdata1", got_d[1], 8'hBB);
         chk("t4_rlast1", got_l[1], 1'b1);
         chk("t4_rid", got_id[1], 4'd5);
      end

      // 5: fill FIFO with no read, then drain with a 16-beat read
      for (int i = 0; i < 16; i++) do_push(8'hC0 + 8'(i));
      @(negedge clk);
      chk("t5_full_rx_ready", rx_ready, 1'b0);
      step();
      do_ar(4'd7, 8'd15);
      collect(16);
      for (int i = 0; i < got_d.size(); i++) begin
         chk("t5_rdata", got_d[i], 8'hC0 + 8'(i));
         chk("t5_rlast", got_l[i], (i == 15));
      end

      // 6: reset in the middle of a write burst, with a byte sitting in the FIFO
      do_push(8'h55);
      do_aw(4'd1, 8'd3);
      do_w(8'h30, 1'b1, 1'b0);
      do_w(8'h31, 1'b1, 1'b0);
      io.wdata = 8'h32; io.wstrb = 1'b1; io.wlast = 1'b0; io.wvalid = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("t6_rst_axi_outs", 32'(axi_outs()), 32'h0);
      chk("t6_rst_stream_outs", {tx_valid, tx_data, rx_ready}, 32'h0);
      io.wvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 sys_rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("t6_awready", io.awready, 1'b1);
      chk("t6_bvalid", io.bvalid, 1'b0);
      chk("t6_rx_ready", rx_ready, 1'b1);
      step();
      do_ar(4'd2, 8'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_fifo_empty", io.rvalid, 1'b0);
         step();
      end
      fork
         do_push(8'h66);
         collect(1);
      join
      if (got_d.size() == 1) chk("t6_rdata", got_d[0], 8'h66);

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, want one");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fcpu_io_axi_bridge.md
Name: fcpu_io_axi_bridge

Overview:
AXI4 slave that terminates the fcpu io master port (io_aw*/io_w*/io_b*/io_ar*/io_r*) and converts it to the byte-stream valid/ready interface of serial_interface. Sits in fcpu_top between fcpu_inst and serial_if_inst. It replaces the tied-off awready/arready/bresp/rlast constants with real burst-aware handshakes. It also buffers received UART bytes in a small FIFO so bytes that arrive before the CPU issues a read are not lost.

Parameters:
FIFO_DEPTH, 16, RX byte FIFO entries; power of two, 2..256
ID_W, 4, AXI ID width

Ports:
clk  input  1  ui_clk domain clock
sys_rst_n  input  1  asynchronous active-low reset
io_awid  input  ID_W  write address ID
io_awlen  input  8  write burst length minus 1
io_awvalid  input  1  write address valid
io_awready  output  1  write address ready
io_wdata  input  8  write byte
io_wstrb  input  1  byte strobe
io_wlast  input  1  last write beat
io_wvalid  input  1  write data valid
io_wready  output  1  write data ready
io_bid  output  ID_W  response ID
io_bresp  output  2  write response
io_bvalid  output  1  response valid
io_bready  input  1  response ready
io_arid  input  ID_W  read address ID
io_arlen  input  8  read burst length minus 1
io_arvalid  input  1  read address valid
io_arready  output  1  read address ready
io_rid  output  ID_W  read ID
io_rdata  output  8  read byte
io_rresp  output  2  read response, always OKAY (00)
io_rlast  output  1  last read beat
io_rvalid  output  1  read data valid
io_rready  input  1  read data ready
tx_data  output  8  byte to serial transmitter
tx_valid  output  1  tx byte valid
tx_ready  input  1  transmitter ready
rx_data  input  8  byte from serial receiver
rx_valid  input  1  rx byte valid
rx_ready  output  1  bridge can accept rx byte

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0 while sys_rst_n is low. FIFO is emptied, both FSMs go to IDLE, all counters clear. io_awready and io_arready rise in the first cycle after reset release.
- Address, size, burst, lock, cache, prot and qos are ignored. Every beat goes to the single data port.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: io_awready=1. On awvalid&awready, latch awid, load wcnt=awlen, clear the err flag, go to W_DATA.
  - W_DATA: tx_data=io_wdata. tx_valid=io_wvalid&io_wstrb. io_wready = io_wstrb ? tx_ready : 1 (a beat with strobe 0 is consumed without emitting a byte).
  - A beat completes on wvalid&wready. Set err if io_wlast != (wcnt==0). If wcnt==0, go to W_RESP; otherwise decrement wcnt. Termination is governed by the counter, not by wlast.
  - W_RESP: io_bvalid=1, io_bid=latched id, io_bresp = err ? SLVERR (10) : OKAY (00). On bready, go to W_IDLE.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: io_arready=1. On arvalid&arready, latch arid, load rcnt=arlen, go to R_DATA.
  - R_DATA: io_rvalid = FIFO not empty. io_rdata = FIFO head. io_rlast = (rcnt==0). io_rid = latched id.
  - On rvalid&rready: pop the FIFO. If rcnt==0, go to R_IDLE; otherwise decrement rcnt.
  - A read stalls with rvalid=0 indefinitely until bytes arrive. There is no timeout.
- Read and write FSMs are fully independent and may be active in the same cycle.
- RX FIFO:
  - rx_ready = not full. Push on rx_valid&rx_ready.
  - A byte pushed into an empty FIFO becomes visible on io_rvalid the next cycle (1-cycle latency).
  - Simultaneous push and pop when not full: both occur and the count is unchanged.
  - When full, rx_ready=0 even if a pop happens in the same cycle, so rx_ready depends only on registered state.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
  - The FIFO accepts bytes in any read-FSM state, including IDLE.
- Outputs depend only on state and registers, except io_wready, tx_valid and tx_data, which are combinational pass-throughs in W_DATA.
- Reset mid-burst: the transaction is abandoned with no B or R response issued, and the FIFO contents are lost.

Test Plan:
1. AW(id=3, len=0), W(0x41, strb=1, last=1), tx_ready=1 -> tx_data=0x41 with a 1-cycle tx_valid pulse; bvalid with bid=3, bresp=00.
2. AW(len=3), bytes 0x10..0x13, tx_ready low for 5 cycles on beat 2 -> wready=0 during the stall; four tx bytes in order; one B response, OKAY.
3. AW(len=1), wlast asserted on beat 0 -> two beats consumed; bresp=10 (SLVERR).
4. AR(id=5, len=1) with FIFO empty, then rx bytes 0xAA and 0xBB 20 cycles later -> rvalid stays 0 until the cycle after the 0xAA push; rdata 0xAA (rlast=0) then 0xBB (rlast=1); rid=5.
5. Push 16 rx bytes with no read active -> rx_ready=0 after the 16th push. AR(len=15) -> all 16 bytes returned in order; rx_ready returns to 1 the cycle after the first pop.
6. Deassert sys_rst_n during beat 2 of a len=3 write burst -> all outputs 0 immediately. After release: awready=1, no bvalid, FIFO empty.
